pending_event_queue: RTL and testbench

- Collects single-cycle event pulses into a pending vector.
- Selects the lowest-numbered pending event (bit 0 = highest priority) and presents its index on a registered valid/ready output.
- Tracks per-bit overflow and counts serviced events.
- Sits directly downstream of the raw 8-bit event/request sources and feeds index consumers such as interrupt dispatch and position decoders.

---
 rtl/pending_event_queue.sv | 115 +++++++++++
 tb/tb_pending_event_queue.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/pending_event_queue.sv
// pending_event_queue
//   Collects single-cycle event pulses into a pending register and presents
//   the lowest-numbered eligible one (bit 0 = highest priority) on a
//   registered valid/ready output stage. It also keeps per-bit sticky
//   overflow flags and counts the events the consumer accepts.
//
// Ports
//   clk          rising-edge clock
//   reset        synchronous, active-high reset
//   ev_in        event pulses, sampled every cycle
//   ev_mask      per-bit enable (1 = enabled); masked pulses are dropped
//   out_valid    out_pos holds a valid event index
//   out_ready    consumer accepts when out_valid & out_ready
//   out_pos      index of the presented event
//   pending      pending register (events captured but not yet presented)
//   ovf_sticky   per-bit sticky overflow flags
//   ovf_clr      clears all of ovf_sticky (a same-cycle overflow still sets)
//   serviced_cnt count of accepted events, wraps at 2^CNT_W
module pending_event_queue #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned IDXW  = 3,
  parameter int unsigned CNT_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WIDTH-1:0]  ev_in,
  input  logic [WIDTH-1:0]  ev_mask,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [IDXW-1:0]   out_pos,
  output logic [WIDTH-1:0]  pending,
  output logic [WIDTH-1:0]  ovf_sticky,
  input  logic              ovf_clr,
  output logic [CNT_W-1:0]  serviced_cnt
);

  logic [WIDTH-1:0] pend_q, pend_d;
  logic             out_valid_q, out_valid_d;
  logic [IDXW-1:0]  out_pos_q, out_pos_d;
  logic [WIDTH-1:0] ovf_q, ovf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [WIDTH-1:0] set_v;
  logic [WIDTH-1:0] elig;
  logic [WIDTH-1:0] load_sel;
  logic [IDXW-1:0]  sel_idx;
  logic             sel_found;
  logic             accept;
  logic             load;

  // Lowest set bit of the eligible vector.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (elig[i] && !sel_found) begin
        sel_found = 1'b1;
        sel_idx   = IDXW'(i);
      end
    end
  end

  always_comb begin
    set_v    = ev_in & ev_mask;
    elig     = pend_q & ev_mask;
    accept   = out_valid_q & out_ready;
    load     = (!out_valid_q | out_ready) & sel_found;

    load_sel = '0;
    if (load) begin
      load_sel[sel_idx] = 1'b1;
    end

    // A new pulse on the bit being loaded re-arms it rather than being lost.
    pend_d = (pend_q & ~load_sel) | set_v;

    // Clear first so that an overflow in the clearing cycle survives.
    ovf_d = ovf_clr ? '0 : ovf_q;
    ovf_d = ovf_d | (set_v & pend_q & ~load_sel);

    out_valid_d = out_valid_q;
    out_pos_d   = out_pos_q;
    if (load) begin
      out_valid_d = 1'b1;
      out_pos_d   = sel_idx;
    end else if (accept) begin
      out_valid_d = 1'b0;
    end

    cnt_d = accept ? cnt_q + 1'b1 : cnt_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q      <= '0;
      out_valid_q <= 1'b0;
      out_pos_q   <= '0;
      ovf_q       <= '0;
      cnt_q       <= '0;
    end else begin
      pend_q      <= pend_d;
      out_valid_q <= out_valid_d;
      out_pos_q   <= out_pos_d;
      ovf_q       <= ovf_d;
      cnt_q       <= cnt_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_pos      = out_pos_q;
  assign pending      = pend_q;
  assign ovf_sticky   = ovf_q;
  assign serviced_cnt = cnt_q;

endmodule

// File: tb/tb_pending_event_queue.sv
// tb_pending_event_queue
//   Directed stimulus against pending_event_queue (CNT_W = 4 so the counter
//   wrap is reachable). A behavioural model of the pending set, the single
//   output slot, the overflow flags and the counter is compared against the
//   DUT on every cycle; literal expectations at key points pin the model.
module tb_pending_event_queue;

  localparam int W  = 8;
  localparam int IW = 3;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [W-1:0]  ev_in;
  logic [W-1:0]  ev_mask;
  logic          out_valid;
  logic          out_ready;
  logic [IW-1:0] out_pos;
  logic [W-1:0]  pending;
  logic [W-1:0]  ovf_sticky;
  logic          ovf_clr;
  logic [CW-1:0] serviced_cnt;

  int checks = 0;
  int errors = 0;
  bit armed  = 1'b0;

  always #5 clk = ~clk;

  pending_event_queue #(.WIDTH(W), .IDXW(IW), .CNT_W(CW)) dut (
    .clk          (clk),
    .reset        (reset),
    .ev_in        (ev_in),
    .ev_mask      (ev_mask),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_pos      (out_pos),
    .pending      (pending),
    .ovf_sticky   (ovf_sticky),
    .ovf_clr      (ovf_clr),
    .serviced_cnt (serviced_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [W-1:0] m_pend, m_ovf;
  bit           m_valid;
  int           m_pos, m_cnt;

  logic [W-1:0] n_pend, n_ovf, n_take;
  bit           n_valid;
  int           n_pos, n_cnt, lowest;

  always @* begin
    lowest = -1;
    for (int i = W - 1; i >= 0; i--)
      if (m_pend[i] && ev_mask[i]) lowest = i;
    n_take  = '0;
    n_valid = m_valid;
    n_pos   = m_pos;
    if ((!m_valid || out_ready) && lowest >= 0) begin
      n_take[lowest] = 1'b1;
      n_valid = 1'b1;
      n_pos   = lowest;
    end else if (m_valid && out_ready) begin
      n_valid = 1'b0;
    end
    n_pend = (m_pend & ~n_take) | (ev_in & ev_mask);
    n_ovf  = (ovf_clr ? '0 : m_ovf) | ((ev_in & ev_mask) & m_pend & ~n_take);
    n_cnt  = (m_valid && out_ready) ? (m_cnt + 1) % (1 << CW) : m_cnt;
  end

  always @(posedge clk) begin
    if (reset) begin
      m_pend <= '0; m_ovf <= '0; m_valid <= 1'b0; m_pos <= 0; m_cnt <= 0;
    end else begin
      m_pend <= n_pend; m_ovf <= n_ovf; m_valid <= n_valid;
      m_pos <= n_pos; m_cnt <= n_cnt;
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      check("model_valid", 32'(out_valid), 32'(m_valid));
      check("model_pos", 32'(out_pos), 32'(m_pos));
      check("model_pending", 32'(pending), 32'(m_pend));
      check("model_ovf", 32'(ovf_sticky), 32'(m_ovf));
      check("model_cnt", 32'(serviced_cnt), 32'(m_cnt));
    end
  end

  // Drive one cycle of inputs, then step past the edge that consumes them.
  task automatic cyc(input logic [W-1:0] ev, input logic [W-1:0] msk,
                     input logic rdy, input logic clr);
    ev_in = ev; ev_mask = msk; out_ready = rdy; ovf_clr = clr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout: simulation did not finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    reset = 1'b1; ev_in = '0; ev_mask = '1; out_ready = 1'b0; ovf_clr = 1'b0;
    @(posedge clk); #1;
    cyc(8'h00, 8'hFF, 1'b0, 1'b0);
    armed = 1'b1;
    check("rst_valid", 32'(out_valid), 0);
    check("rst_pend", 32'(pending), 0);
    check("rst_cnt", 32'(serviced_cnt), 0);
    reset = 1'b0;

    // 1: burst 0xA4 drained in priority order
    cyc(8'hA4, 8'hFF, 1'b1, 1'b0);
    check("t1_pend", 32'(pending), 32'hA4);
    check("t1_valid0", 32'(out_valid), 0);
    cyc(8'h00, 8'hFF, 1'b1, 1'b0);
    check("t1_pos2", 32'(out_pos), 2);
    check("t1_v2", 32'(out_valid), 1);
    cyc(8'h00, 8'hFF, 1'b1, 1'b0);
    check("t1_pos5", 32'(out_pos), 5);
    cyc(8'h00, 8'hFF, 1'b1, 1'b0);
    check("t1_pos7", 32'(out_pos), 7);
    check("t1_pend0", 32'(pending), 0);
    cyc(8'h00, 8'hFF, 1'b1, 1'b0);
    check("t1_vlow", 32'(out_valid), 0);
    check("t1_cnt3", 32'(serviced_cnt), 3);

    // 2: backpressure
    cyc(8'h80, 8'hFF, 1'b0, 1'b0);
    cyc(8'h01, 8'hFF, 1'b0, 1'b0);
    check("t2_pos7", 32'(out_pos), 7);
    check("t2_pend01", 32'(pending), 32'h01);
    for (int k = 0; k < 3; k++) begin
      cyc(8'h00, 8'hFF, 1'b0, 1'b0);
      check("t2_hold", 32'({out_valid, out_pos}), 32'({1'b1, 3'd7}));
    end
    cyc(8'h00, 8'hFF, 1'b1, 1'b0);
    check("t2_pos0", 32'({out_valid, out_pos}), 32'({1'b1, 3'd0}));
    cyc(8'h00, 8'hFF, 1'b1, 1'b0);
    check("t2_vlow", 32'(out_valid), 0);

    // 3: overflow
    cyc(8'h10, 8'hFF, 1'b0, 1'b0);
    cyc(8'h10, 8'hFF, 1'b0, 1'b0);
    check("t3_noovf", 32'(ovf_sticky), 0);
    cyc(8'h10, 8'hFF, 1'b0, 1'b0);
    check("t3_pos4", 32'(out_pos), 4);
    check("t3_ovf", 32'(ovf_sticky), 32'h10);
    cyc(8'h00, 8'hFF, 1'b0, 1'b1);
    check("t3_clr", 32'(ovf_sticky), 0);
    cyc(8'h10, 8'hFF, 1'b0, 1'b1);
    check("t3_setwins", 32'(ovf_sticky), 32'h10);
    cyc(8'h00, 8'hFF, 1'b1, 1'b1);
    cyc(8'h00, 8'hFF, 1'b1, 1'b0);
    check("t3_drain", 32'({out_valid, pending}), 0);

    // 4: masking
    cyc(8'h03, 8'hFE, 1'b1, 1'b0);
    check("t4_pend02", 32'(pending), 32'h02);
    cyc(8'h00, 8'hFE, 1'b1, 1'b0);
    check("t4_pos1", 32'({out_valid, out_pos}), 32'({1'b1, 3'd1}));
    cyc(8'h00, 8'hFE, 1'b1, 1'b0);
    check("t4_vlow", 32'(out_valid), 0);
    cyc(8'h80, 8'hFF, 1'b0, 1'b0);
    cyc(8'h00, 8'hFF, 1'b0, 1'b0);
    cyc(8'h0C, 8'hFF, 1'b0, 1'b0);
    check("t4_pos7", 32'(out_pos), 7);
    check("t4_pend0c", 32'(pending), 32'h0C);
    cyc(8'h00, 8'hF3, 1'b1, 1'b0);
    check("t4_masked_vlow", 32'(out_valid), 0);
    check("t4_retained", 32'(pending), 32'h0C);
    cyc(8'h00, 8'hFF, 1'b1, 1'b0);
    check("t4_pos2", 32'({out_valid, out_pos}), 32'({1'b1, 3'd2}));
    cyc(8'h00, 8'hFF, 1'b1, 1'b0);
    check("t4_pos3", 32'({out_valid, out_pos}), 32'({1'b1, 3'd3}));
    cyc(8'h00, 8'hFF, 1'b1, 1'b0);

    // 5: counter wrap (4-bit counter, 17 accepts from zero)
    reset = 1'b1;
    cyc(8'h00, 8'hFF, 1'b0, 1'b0);
    reset = 1'b0;
    for (int k = 0; k < 17; k++) cyc(8'h01, 8'hFF, 1'b1, 1'b0);
    check("t5_cnt15", 32'(serviced_cnt), 15);
    cyc(8'h00, 8'hFF, 1'b1, 1'b0);
    check("t5_cnt0", 32'(serviced_cnt), 0);
    cyc(8'h00, 8'hFF, 1'b1, 1'b0);
    check("t5_cnt1", 32'(serviced_cnt), 1);
    check("t5_vlow", 32'(out_valid), 0);

    // 6: reset mid-operation
    cyc(8'h01, 8'hFF, 1'b0, 1'b0);
    cyc(8'h3C, 8'hFF, 1'b0, 1'b0);
    cyc(8'h3C, 8'hFF, 1'b0, 1'b0);
    check("t6_pre_pend", 32'(pending), 32'h3C);
    check("t6_pre_valid", 32'(out_valid), 1);
    reset = 1'b1;
    cyc(8'hFF, 8'hFF, 1'b0, 1'b0);
    reset = 1'b0;
    check("t6_valid", 32'(out_valid), 0);
    check("t6_pend", 32'(pending), 0);
    check("t6_ovf", 32'(ovf_sticky), 0);
    check("t6_cnt", 32'(serviced_cnt), 0);
    cyc(8'h00, 8'hFF, 1'b1, 1'b0);
    check("t6_discard", 32'({out_valid, pending}), 0);

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
